// File: rtl/pc_gen.sv
// pc_gen: RV32I program-counter generator.
// Boot hold after reset, then a fixed-priority choice of next PC
// (trap > mret > branch > jump > sequential). A misaligned redirect
// target parks the generator until a trap redirect arrives.
module pc_gen #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          BOOT_DELAY   = 4,
  parameter int unsigned          INSN_BYTES   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] misaligned_addr
);

  // Counter only needs to reach BOOT_DELAY-1.
  localparam int unsigned CW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;

  typedef enum logic [1:0] {BOOT, RUN, PARK} state_t;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] tgt;
  } redir_t;

  state_t          state;
  logic [CW-1:0]   boot_cnt;
  redir_t          redir;
  logic            redir_bad;
  logic [XLEN-1:0] trap_pc;

  assign pc_plus4 = pc + XLEN'(INSN_BYTES);

  // Trap handler base is force-aligned; it is never misalignment-checked.
  assign trap_pc = trap_vector & ~XLEN'(3);

  // Winner among the checked redirect sources; losers are simply dropped.
  always_comb begin
    redir = '0;
    if (mret) begin
      redir.vld = 1'b1;
      redir.tgt = epc;
    end else if (branch_taken) begin
      redir.vld = 1'b1;
      redir.tgt = branch_target;
    end else if (jump) begin
      redir.vld = 1'b1;
      redir.tgt = jump_target;
    end
  end

  assign redir_bad = redir.vld && (redir.tgt[1:0] != 2'b00);

  // Boot/run/park control with registered PC and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= BOOT;
      boot_cnt        <= '0;
      pc              <= RESET_VECTOR;
      pc_valid        <= 1'b0;
      misaligned      <= 1'b0;
      misaligned_addr <= '0;
    end else begin
      misaligned <= 1'b0;
      unique case (state)
        BOOT: begin
          if (boot_cnt == CW'(BOOT_DELAY - 1)) begin
            state    <= RUN;
            pc_valid <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + CW'(1);
          end
        end
        RUN: begin
          if (trap) begin
            pc <= trap_pc;
          end else if (redir.vld) begin
            if (redir_bad) begin
              // Reject: keep old pc, flag the bad target and wait for a trap.
              misaligned      <= 1'b1;
              misaligned_addr <= redir.tgt;
              state           <= PARK;
              pc_valid        <= 1'b0;
            end else begin
              pc <= redir.tgt;
            end
          end else if (fetch_ready && !stall) begin
            pc <= pc_plus4;
          end
        end
        PARK: begin
          if (trap) begin
            pc       <= trap_pc;
            state    <= RUN;
            pc_valid <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pc_gen;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h0;
  localparam int unsigned BD   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, fetch_ready = 1'b1;
  logic        branch_taken = 1'b0, jump = 1'b0, trap = 1'b0, mret = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0, trap_vector = '0, epc = '0;
  logic [31:0] pc, pc_plus4, misaligned_addr;
  logic        pc_valid, misaligned;

  int checks = 0;
  int failures = 0;

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .BOOT_DELAY(BD), .INSN_BYTES(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .trap(trap), .trap_vector(trap_vector),
    .mret(mret), .epc(epc),
    .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid),
    .misaligned(misaligned), .misaligned_addr(misaligned_addr)
  );

  always #5 clk = ~clk;

  // Behavioural model: cycles of boot left, parked flag, architectural pc.
  int          m_boot_left = BD;
  bit          m_parked = 1'b0;
  logic [31:0] m_pc = RV;
  bit          m_mis = 1'b0;
  logic [31:0] m_mis_addr = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_boot_left = BD; m_parked = 1'b0; m_pc = RV; m_mis = 1'b0; m_mis_addr = '0;
    end else begin
      m_mis = 1'b0;
      if (m_boot_left > 0) begin
        m_boot_left = m_boot_left - 1;
      end else if (m_parked) begin
        if (trap) begin m_pc = {trap_vector[31:2], 2'b00}; m_parked = 1'b0; end
      end else if (trap) begin
        m_pc = {trap_vector[31:2], 2'b00};
      end else if (mret || branch_taken || jump) begin
        logic [31:0] t;
        t = mret ? epc : (branch_taken ? branch_target : jump_target);
        if (t % 4 != 0) begin
          m_mis = 1'b1; m_mis_addr = t; m_parked = 1'b1;
        end else begin
          m_pc = t;
        end
      end else if (fetch_ready && !stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_pc", pc, m_pc);
    chk("model_pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("model_valid", {31'd0, pc_valid}, {31'd0, (m_boot_left == 0) && !m_parked});
    chk("model_mis", {31'd0, misaligned}, {31'd0, m_mis});
    chk("model_mis_addr", misaligned_addr, m_mis_addr);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    branch_taken = 0; jump = 0; trap = 0; mret = 0;
  endtask

  task automatic boot_seq(input string tag);
    for (int i = 1; i < BD; i++) begin
      step(); chk({tag, "_boot_valid_low"}, {31'd0, pc_valid}, 32'd0);
    end
    step();
    chk({tag, "_boot_valid_high"}, {31'd0, pc_valid}, 32'd1);
    chk({tag, "_boot_pc"}, pc, RV);
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_mis_addr", misaligned_addr, 32'h0);

    rst = 1'b1;
    boot_seq("first");
    step(); chk("seq_4", pc, 32'h4);
    step(); chk("seq_8", pc, 32'h8);
    step(); chk("seq_c", pc, 32'hC);
    chk("seq_plus4", pc_plus4, 32'h10);
    step(); chk("seq_10", pc, 32'h10);

    // stall then no fetch_ready: pc must hold
    stall = 1;
    repeat (3) begin step(); chk("stall_hold", pc, 32'h10); end
    stall = 0; fetch_ready = 0;
    repeat (2) begin step(); chk("fr_hold", pc, 32'h10); end
    fetch_ready = 1;
    step(); chk("resume_14", pc, 32'h14);

    // trap beats branch and jump, and is force-aligned
    trap = 1; trap_vector = 32'h203; branch_taken = 1; branch_target = 32'h40;
    jump = 1; jump_target = 32'h44;
    step(); clr();
    chk("prio_trap_pc", pc, 32'h200);
    chk("prio_no_mis", {31'd0, misaligned}, 32'd0);

    // misaligned branch parks
    fetch_ready = 0; jump = 1; jump_target = 32'h80;
    step(); clr(); chk("jump_80", pc, 32'h80);
    branch_taken = 1; branch_target = 32'h42;
    step(); clr(); fetch_ready = 1;
    chk("mis_pc_hold", pc, 32'h80);
    chk("mis_pulse", {31'd0, misaligned}, 32'd1);
    chk("mis_addr", misaligned_addr, 32'h42);
    chk("mis_valid_low", {31'd0, pc_valid}, 32'd0);
    jump = 1; jump_target = 32'h100;
    step(); clr();
    chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);
    chk("park_ignore_jump", pc, 32'h80);
    chk("park_addr_hold", misaligned_addr, 32'h42);
    trap = 1; trap_vector = 32'h300;
    step(); clr();
    chk("park_trap_pc", pc, 32'h300);
    chk("park_trap_valid", {31'd0, pc_valid}, 32'd1);

    // wrap-around
    fetch_ready = 0; jump = 1; jump_target = 32'hFFFF_FFFC;
    step(); clr();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    fetch_ready = 1;
    step(); chk("wrap_to_0", pc, 32'h0);

    // async reset mid-PARK
    jump = 1; jump_target = 32'h500;
    step(); clr();
    branch_taken = 1; branch_target = 32'h6;
    step(); clr();
    chk("park2_pc", pc, 32'h500);
    #2 rst = 0; #1;
    chk("rst_park_pc", pc, RV);
    chk("rst_park_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_park_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_park_addr", misaligned_addr, 32'h0);
    step(); rst = 1;
    boot_seq("after_park");

    // async reset mid-BOOT
    #2 rst = 0; #1; step(); rst = 1;
    step(); step();
    #2 rst = 0; #1;
    chk("rst_boot_pc", pc, RV);
    chk("rst_boot_valid", {31'd0, pc_valid}, 32'd0);
    step(); rst = 1;
    boot_seq("after_boot");

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      stall         = ($urandom_range(3) == 0);
      fetch_ready   = ($urandom_range(3) != 0);
      trap          = ($urandom_range(15) == 0);
      mret          = ($urandom_range(15) == 0);
      branch_taken  = ($urandom_range(7) == 0);
      jump          = ($urandom_range(7) == 0);
      trap_vector   = $urandom;
      epc           = $urandom;
      branch_target = $urandom;
      jump_target   = $urandom;
      if ($urandom_range(3) != 0) epc[1:0] = 2'b00;
      if ($urandom_range(3) != 0) branch_target[1:0] = 2'b00;
      if ($urandom_range(3) != 0) jump_target[1:0] = 2'b00;
      step();
    end
    clr();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
